// File: rtl/snoop_responder.sv
// rtl/snoop_responder.sv - MESI snoop responder: tag lookup, block supply, state downgrade
//
// Purpose: services one bus snoop at a time against the L1 tag/state/data arrays.
// A snoop is accepted in IDLE, the tags of the addressed set are compared the next
// cycle, an E/M block is read out of the data array when this cache owns it, and the
// response is held until the bus controller drops snoop_valid. The line is then
// invalidated (snoop_inv) or downgraded from E/M to S with a single state write.
//
// Ports:
//   CLK, nRST                       clock (rising edge), asynchronous active-low reset
//   snoop_valid/addr/inv            snoop request from the bus controller (held until done)
//   snoop_done/hit/present/dirty    response flags, valid while snoop_done is high
//   snoop_data                      block supplied on an E/M match
//   busy                            responder owns the arrays (not IDLE)
//   tag_rd_en/idx, tag_rd_tag/state tag+state array read, data one cycle after the strobe
//   data_rd_en/idx/way, data_rd_data data array read, data one cycle after the strobe
//   state_wr_en/idx/way/state       single-cycle state array write
module snoop_responder #(
  parameter int BLOCK_SIZE = 2,
  parameter int SETS       = 16,
  parameter int ASSOC      = 2,
  localparam int OFF  = 2 + $clog2(BLOCK_SIZE),
  localparam int IDX  = $clog2(SETS),
  localparam int TAG  = 32 - OFF - IDX,
  localparam int WAYW = (ASSOC > 1) ? $clog2(ASSOC) : 1,
  localparam int DW   = 32 * BLOCK_SIZE
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              snoop_valid,
  input  logic [31:0]       snoop_addr,
  input  logic              snoop_inv,
  output logic              snoop_done,
  output logic              snoop_hit,
  output logic              snoop_present,
  output logic              snoop_dirty,
  output logic [DW-1:0]     snoop_data,
  output logic              busy,
  output logic              tag_rd_en,
  output logic [IDX-1:0]    tag_rd_idx,
  input  logic [ASSOC*TAG-1:0] tag_rd_tag,
  input  logic [ASSOC*2-1:0]   tag_rd_state,
  output logic              data_rd_en,
  output logic [IDX-1:0]    data_rd_idx,
  output logic [WAYW-1:0]   data_rd_way,
  input  logic [DW-1:0]     data_rd_data,
  output logic              state_wr_en,
  output logic [IDX-1:0]    state_wr_idx,
  output logic [WAYW-1:0]   state_wr_way,
  output logic [1:0]        state_wr_state
);

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_M = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_DATA,
    ST_RESPOND,
    ST_UPDATE
  } fsm_t;

  fsm_t state, next_state;

  // Latched snoop (block address only; offset bits carry no meaning here)
  logic [31-OFF:0]  addr_q;
  logic             inv_q;
  logic             hit_q;
  logic             present_q;
  logic             dirty_q;
  logic [WAYW-1:0]  way_q;
  logic [DW-1:0]    data_q;

  logic [IDX-1:0]   addr_idx;
  logic [TAG-1:0]   addr_tag;
  logic             unused_offset;

  assign addr_idx      = addr_q[IDX-1:0];
  assign addr_tag      = addr_q[31-OFF:IDX];
  assign unused_offset = ^snoop_addr[OFF-1:0];

  // Way compare; iterating downward leaves the lowest matching way selected.
  logic             match_found;
  logic [WAYW-1:0]  match_way;
  logic [1:0]       match_state;
  logic             match_em;

  always_comb begin
    match_found = 1'b0;
    match_way   = '0;
    match_state = MESI_I;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (tag_rd_tag[w*TAG +: TAG] == addr_tag && tag_rd_state[w*2 +: 2] != MESI_I) begin
        match_found = 1'b1;
        match_way   = WAYW'(w);
        match_state = tag_rd_state[w*2 +: 2];
      end
    end
  end

  assign match_em = match_found && match_state[1];

  // A state write is needed when the line is present and must either be
  // invalidated or lose its exclusive ownership.
  logic need_update;
  assign need_update = present_q && (inv_q || hit_q);

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (snoop_valid) next_state = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (!snoop_valid)  next_state = ST_IDLE;
        else if (match_em) next_state = ST_DATA;
        else               next_state = ST_RESPOND;
      end
      ST_DATA: begin
        if (!snoop_valid) next_state = ST_IDLE;
        else              next_state = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (!snoop_valid) next_state = need_update ? ST_UPDATE : ST_IDLE;
      end
      ST_UPDATE: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q    <= '0;
      inv_q     <= 1'b0;
      hit_q     <= 1'b0;
      present_q <= 1'b0;
      dirty_q   <= 1'b0;
      way_q     <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (snoop_valid) begin
            addr_q    <= snoop_addr[31:OFF];
            inv_q     <= snoop_inv;
            hit_q     <= 1'b0;
            present_q <= 1'b0;
            dirty_q   <= 1'b0;
            way_q     <= '0;
            data_q    <= '0;
          end
        end
        ST_COMPARE: begin
          if (snoop_valid) begin
            hit_q     <= match_em;
            present_q <= match_found;
            dirty_q   <= match_found && (match_state == MESI_M);
            way_q     <= match_way;
          end
        end
        ST_DATA: begin
          if (snoop_valid) data_q <= data_rd_data;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy           = (state != ST_IDLE);
    // Gated by nRST so the combinational accept path is also quiet during reset.
    tag_rd_en      = (state == ST_IDLE) && snoop_valid && nRST;
    tag_rd_idx     = tag_rd_en ? snoop_addr[OFF+IDX-1:OFF] : addr_idx;
    data_rd_en     = (state == ST_COMPARE) && snoop_valid && match_em;
    data_rd_idx    = addr_idx;
    data_rd_way    = data_rd_en ? match_way : way_q;
    state_wr_en    = (state == ST_UPDATE);
    state_wr_idx   = addr_idx;
    state_wr_way   = way_q;
    state_wr_state = (state == ST_UPDATE && !inv_q) ? MESI_S : MESI_I;
    snoop_done     = (state == ST_RESPOND);
    snoop_hit      = snoop_done && hit_q;
    snoop_present  = snoop_done && present_q;
    snoop_dirty    = snoop_done && dirty_q;
    snoop_data     = data_q;
  end

endmodule

// File: tb/tb_snoop_responder.sv
// tb/tb_snoop_responder.sv - randomized self-checking bench for snoop_responder
module tb_snoop_responder;

  localparam int BLOCK_SIZE = 2;
  localparam int SETS       = 16;
  localparam int ASSOC      = 2;
  localparam int OFF  = 3;
  localparam int IDX  = 4;
  localparam int TAG  = 25;
  localparam int WAYW = 1;
  localparam int DW   = 64;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              snoop_valid;
  logic [31:0]       snoop_addr;
  logic              snoop_inv;
  logic              snoop_done, snoop_hit, snoop_present, snoop_dirty;
  logic [DW-1:0]     snoop_data;
  logic              busy;
  logic              tag_rd_en;
  logic [IDX-1:0]    tag_rd_idx;
  logic [ASSOC*TAG-1:0] tag_rd_tag;
  logic [ASSOC*2-1:0]   tag_rd_state;
  logic              data_rd_en;
  logic [IDX-1:0]    data_rd_idx;
  logic [WAYW-1:0]   data_rd_way;
  logic [DW-1:0]     data_rd_data;
  logic              state_wr_en;
  logic [IDX-1:0]    state_wr_idx;
  logic [WAYW-1:0]   state_wr_way;
  logic [1:0]        state_wr_state;

  snoop_responder #(.BLOCK_SIZE(BLOCK_SIZE), .SETS(SETS), .ASSOC(ASSOC)) dut (
    .CLK(CLK), .nRST(nRST),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_inv(snoop_inv),
    .snoop_done(snoop_done), .snoop_hit(snoop_hit), .snoop_present(snoop_present),
    .snoop_dirty(snoop_dirty), .snoop_data(snoop_data), .busy(busy),
    .tag_rd_en(tag_rd_en), .tag_rd_idx(tag_rd_idx),
    .tag_rd_tag(tag_rd_tag), .tag_rd_state(tag_rd_state),
    .data_rd_en(data_rd_en), .data_rd_idx(data_rd_idx), .data_rd_way(data_rd_way),
    .data_rd_data(data_rd_data),
    .state_wr_en(state_wr_en), .state_wr_idx(state_wr_idx),
    .state_wr_way(state_wr_way), .state_wr_state(state_wr_state)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errors  = 0;
  int wr_count = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Cache arrays seen by the responder; the model owns their MESI state.
  logic [TAG-1:0] mem_tag  [SETS][ASSOC];
  logic [1:0]     mem_st   [SETS][ASSOC];
  logic [DW-1:0]  mem_data [SETS][ASSOC];

  logic [IDX-1:0]  tag_idx_q  = '0;
  logic [IDX-1:0]  data_idx_q = '0;
  logic [WAYW-1:0] data_way_q = '0;

  always @(posedge CLK) begin
    if (tag_rd_en)  tag_idx_q <= tag_rd_idx;
    if (data_rd_en) begin
      data_idx_q <= data_rd_idx;
      data_way_q <= data_rd_way;
    end
    if (state_wr_en) wr_count++;
  end

  always_comb begin
    tag_rd_tag   = '0;
    tag_rd_state = '0;
    for (int w = 0; w < ASSOC; w++) begin
      tag_rd_tag[w*TAG +: TAG] = mem_tag[tag_idx_q][w];
      tag_rd_state[w*2 +: 2]   = mem_st[tag_idx_q][w];
    end
  end
  assign data_rd_data = mem_data[data_idx_q][data_way_q];

  // Always-on rules: one array strobe per cycle, flags silent outside the response.
  always @(negedge CLK) begin
    if (nRST) begin
      chk("strobe_excl", 64'(int'(tag_rd_en) + int'(data_rd_en) + int'(state_wr_en) <= 1), 64'd1);
      if (!snoop_done)
        chk("flags_quiet", {61'd0, snoop_hit, snoop_present, snoop_dirty}, 64'd0);
    end
  end

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> OFF) % SETS);
  endfunction

  function automatic logic [31:0] mk_addr(input int tag, input int set, input int off);
    return (32'(tag) << (OFF + IDX)) | (32'(set) << OFF) | 32'(off);
  endfunction

  task automatic wait_idle();
    for (int n = 0; n < 20 && busy; n++) @(negedge CLK);
    chk("idle_wait", busy, 0);
  endtask

  // One snoop from acceptance to return to IDLE, checked against the MESI rules.
  task automatic snoop(input logic [31:0] a, input logic i, input bit chain_in,
                       input bit chain_out, input logic [31:0] na, input logic ni);
    int set, lat, hold, found_way;
    logic [TAG-1:0] tg;
    logic [1:0] st;
    bit found, exp_hit, exp_wr, rd_seen;
    logic [DW-1:0] exp_data;
    set = set_of(a);
    tg  = TAG'(a >> (OFF + IDX));
    found = 0; found_way = 0; st = 2'd0;
    for (int w = 0; w < ASSOC; w++)
      if (!found && mem_tag[set][w] == tg && mem_st[set][w] != 2'd0) begin
        found = 1; found_way = w; st = mem_st[set][w];
      end
    exp_hit  = found && st >= 2'd2;
    exp_data = exp_hit ? mem_data[set][found_way] : '0;
    exp_wr   = found && (i || exp_hit);

    if (chain_in) begin
      @(negedge CLK);
    end else begin
      wait_idle();
      snoop_valid = 1'b1; snoop_addr = a; snoop_inv = i;
    end
    #1;
    chk("accept_en", tag_rd_en, 1);
    chk("accept_idx", tag_rd_idx, 64'(set));
    chk("accept_busy", busy, 0);

    lat = 0; rd_seen = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        rd_seen = data_rd_en;
        if (data_rd_en) chk("data_rd_way", data_rd_way, 64'(found_way));
        snoop_addr = $urandom;
        snoop_inv  = 1'($urandom);
      end
      if (snoop_done) begin lat = c; break; end
    end
    chk("data_rd", rd_seen, exp_hit);
    chk("latency", lat, exp_hit ? 3 : 2);
    chk("hit", snoop_hit, exp_hit);
    chk("present", snoop_present, found);
    chk("dirty", snoop_dirty, found && st == 2'd3);
    chk("data", snoop_data, exp_data);

    hold = $urandom_range(0, 2);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk("hold_done", snoop_done, 1);
      chk("hold_data", snoop_data, exp_data);
    end
    snoop_valid = 1'b0;
    @(negedge CLK);
    chk("wr_en", state_wr_en, exp_wr);
    if (exp_wr) begin
      chk("wr_idx", state_wr_idx, 64'(set));
      chk("wr_way", state_wr_way, 64'(found_way));
      chk("wr_state", state_wr_state, i ? 0 : 1);
      mem_st[set][found_way] = i ? 2'd0 : 2'd1;
      if (chain_out) begin
        snoop_valid = 1'b1; snoop_addr = na; snoop_inv = ni;
      end
    end else begin
      chk("idle_after", busy, 0);
    end
  endtask

  // Snoop withdrawn in COMPARE or DATA: no response and no state write.
  task automatic abort_snoop(input logic [31:0] a, input bit in_data);
    int w0;
    wait_idle();
    w0 = wr_count;
    snoop_valid = 1'b1; snoop_addr = a; snoop_inv = 1'($urandom);
    @(negedge CLK);
    chk("abort_done_c", snoop_done, 0);
    if (in_data) begin
      chk("abort_rd", data_rd_en, 1);
      @(negedge CLK);
      chk("abort_done_d", snoop_done, 0);
    end
    snoop_valid = 1'b0;
    @(negedge CLK);
    chk("abort_idle", busy, 0);
    chk("abort_done", snoop_done, 0);
    @(negedge CLK);
    chk("abort_nowr", wr_count, w0);
  endtask

  initial begin
    logic [31:0] a, b;
    int w0;
    nRST = 1'b0; snoop_valid = 1'b0; snoop_addr = '0; snoop_inv = 1'b0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < ASSOC; w++) begin
        mem_tag[s][w]  = TAG'($urandom_range(0, 3));
        mem_st[s][w]   = 2'($urandom_range(0, 3));
        mem_data[s][w] = {$urandom, $urandom};
      end
    repeat (3) @(negedge CLK);
    chk("rst_done", snoop_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", snoop_data, 0);
    chk("rst_wr", state_wr_en, 0);
    nRST = 1'b1;
    @(negedge CLK);

    // Miss at 0x1040 (set 8, tag 0x20), all ways invalid
    for (int w = 0; w < ASSOC; w++) mem_st[8][w] = 2'd0;
    snoop(32'h0000_1040, 1'b0, 0, 0, 0, 0);

    // Modified hit in way 1, read
    mem_tag[2][0] = 25'd5; mem_st[2][0] = 2'd1;
    mem_tag[2][1] = 25'd9; mem_st[2][1] = 2'd3;
    mem_data[2][1] = 64'hDEADBEEF_CAFEF00D;
    snoop(mk_addr(9, 2, 4), 1'b0, 0, 0, 0, 0);

    // Shared match with invalidate
    mem_tag[3][0] = 25'd7; mem_st[3][0] = 2'd1; mem_st[3][1] = 2'd0;
    snoop(mk_addr(7, 3, 0), 1'b1, 0, 0, 0, 0);

    // Exclusive hit, then a snoop raised during UPDATE
    mem_tag[4][0] = 25'd2; mem_st[4][0] = 2'd2;
    b = mk_addr($urandom_range(0, 3), $urandom_range(0, SETS - 1), 0);
    snoop(mk_addr(2, 4, 0), 1'b0, 0, 1, b, 1'b0);
    snoop(b, 1'b0, 1, 0, 0, 0);

    // Abort in DATA
    mem_tag[5][1] = 25'd1; mem_st[5][1] = 2'd3; mem_st[5][0] = 2'd0;
    abort_snoop(mk_addr(1, 5, 0), 1);

    // Reset while responding
    mem_tag[6][0] = 25'd3; mem_st[6][0] = 2'd3;
    wait_idle();
    w0 = wr_count;
    snoop_valid = 1'b1; snoop_addr = mk_addr(3, 6, 0); snoop_inv = 1'b1;
    repeat (3) @(negedge CLK);
    chk("pre_rst_done", snoop_done, 1);
    nRST = 1'b0;
    #1;
    chk("rst_mid_done", snoop_done, 0);
    chk("rst_mid_flags", {snoop_hit, snoop_present, snoop_dirty}, 0);
    chk("rst_mid_data", snoop_data, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_strobes", {tag_rd_en, data_rd_en, state_wr_en}, 0);
    snoop_valid = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_mid_nowr", wr_count, w0);

    // Random traffic over a small tag pool so multi-way matches occur
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        int s, w;
        s = $urandom_range(0, SETS - 1);
        w = $urandom_range(0, ASSOC - 1);
        mem_st[s][w] = 2'($urandom_range(0, 3));
      end
      a = mk_addr($urandom_range(0, 3), $urandom_range(0, SETS - 1), $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) abort_snoop(a, 0);
      else snoop(a, 1'($urandom), 0, 0, 0, 0);
    end

    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
